// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus: arbiter state encodings and the
// default timing constants that masters and slaves align their own timeouts to.
package bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HOLD = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int DEFAULT_GAP_CYCLES     = 2;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then map the position back to a master index.
module rr_select #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_WIDTH    = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [ID_WIDTH-1:0]    ptr,
  output logic                   valid,
  output logic [ID_WIDTH-1:0]    winner
);

  localparam int SW = ID_WIDTH + 1;
  localparam logic [SW-1:0] NUM_M = SW'(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] rot;
  logic [ID_WIDTH-1:0]    pos;

  // Modular add; both operands are always below NUM_MASTERS so one subtract suffices.
  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] a,
                                                   input logic [ID_WIDTH-1:0] b);
    logic [SW-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= NUM_M) s = s - NUM_M;
    return s[ID_WIDTH-1:0];
  endfunction

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_rot
    assign rot[gi] = req[wrap_add(ID_WIDTH'(gi), ptr)];
  end

  always_comb begin
    pos = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (rot[i]) pos = ID_WIDTH'(i);
    end
  end

  assign valid  = |req;
  assign winner = wrap_add(pos, ptr);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: one owner at a time, hold timeout frozen by
// slave_busy, and a fixed idle gap between tenures for driver turnaround.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
  parameter int ID_WIDTH       = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] m_req,
  input  logic                   slave_busy,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [ID_WIDTH-1:0]    grant_id,
  output logic                   bus_util,
  output logic                   timeout_err,
  output logic [ID_WIDTH-1:0]    timeout_id
);

  localparam int HW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

  arb_state_t             state_reg;
  logic [NUM_MASTERS-1:0] grant_reg;
  logic [ID_WIDTH-1:0]    grant_id_reg;
  logic                   bus_util_reg;
  logic                   timeout_err_reg;
  logic [ID_WIDTH-1:0]    timeout_id_reg;
  logic [HW-1:0]          hold_cnt_reg;
  logic [GW-1:0]          gap_cnt_reg;
  logic [ID_WIDTH-1:0]    rr_ptr_reg;

  logic                   sel_valid;
  logic [ID_WIDTH-1:0]    sel_winner;
  logic [ID_WIDTH-1:0]    ptr_next;
  logic                   owner_req;
  logic                   hold_expired;

  rr_select #(
    .NUM_MASTERS(NUM_MASTERS),
    .ID_WIDTH   (ID_WIDTH)
  ) u_rr_select (
    .req   (m_req),
    .ptr   (rr_ptr_reg),
    .valid (sel_valid),
    .winner(sel_winner)
  );

  assign owner_req    = m_req[grant_id_reg];
  assign hold_expired = !slave_busy && (hold_cnt_reg == HW'(TIMEOUT_CYCLES - 1));
  assign ptr_next     = (grant_id_reg == ID_WIDTH'(NUM_MASTERS - 1)) ? '0
                                                                     : grant_id_reg + ID_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ARB_IDLE;
      grant_reg       <= '0;
      grant_id_reg    <= '0;
      bus_util_reg    <= 1'b0;
      timeout_err_reg <= 1'b0;
      timeout_id_reg  <= '0;
      hold_cnt_reg    <= '0;
      gap_cnt_reg     <= '0;
      rr_ptr_reg      <= '0;
    end else begin
      timeout_err_reg <= 1'b0;
      case (state_reg)
        ARB_IDLE: begin
          if (sel_valid) begin
            grant_reg    <= ONE_HOT0 << sel_winner;
            grant_id_reg <= sel_winner;
            bus_util_reg <= 1'b1;
            hold_cnt_reg <= '0;
            state_reg    <= ARB_HOLD;
          end
        end
        ARB_HOLD: begin
          // A voluntary release wins over an expiring counter in the same cycle.
          if (!owner_req || hold_expired) begin
            grant_reg    <= '0;
            bus_util_reg <= 1'b0;
            rr_ptr_reg   <= ptr_next;
            gap_cnt_reg  <= '0;
            state_reg    <= ARB_GAP;
            if (owner_req) begin
              timeout_err_reg <= 1'b1;
              timeout_id_reg  <= grant_id_reg;
            end
          end else if (!slave_busy) begin
            hold_cnt_reg <= hold_cnt_reg + HW'(1);
          end
        end
        ARB_GAP: begin
          if (gap_cnt_reg == GW'(GAP_CYCLES - 1)) begin
            gap_cnt_reg <= '0;
            state_reg   <= ARB_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GW'(1);
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

  assign grant       = grant_reg;
  assign grant_id    = grant_id_reg;
  assign bus_util    = bus_util_reg;
  assign timeout_err = timeout_err_reg;
  assign timeout_id  = timeout_id_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, round-robin order, gap latency,
// wrap-around, hold timeout with and without slave_busy freeze, and races.
module tb_bus_arbiter;

  localparam int NM = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NM-1:0] m_req;
  logic          slave_busy;
  logic [NM-1:0] grant;
  logic [IW-1:0] grant_id;
  logic          bus_util;
  logic          timeout_err;
  logic [IW-1:0] timeout_id;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bus_arbiter #(
    .NUM_MASTERS   (NM),
    .TIMEOUT_CYCLES(8),
    .GAP_CYCLES    (2),
    .ID_WIDTH      (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_req      (m_req),
    .slave_busy (slave_busy),
    .grant      (grant),
    .grant_id   (grant_id),
    .bus_util   (bus_util),
    .timeout_err(timeout_err),
    .timeout_id (timeout_id)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; returns 1 ns after the last edge so outputs are settled.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Step until any grant appears (bounded); reports edges taken.
  task automatic wait_grant(output int n);
    n = 0;
    while (grant == '0 && n < 12) begin
      step(1);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; m_req = 4'b1111; slave_busy = 1'b0;
    step(2);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    checks++; if (bus_util !== 1'b0) begin errors++; $display("FAIL reset_bus_util got %b want 0", bus_util); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
    checks++; if (timeout_id !== 2'd0) begin errors++; $display("FAIL reset_timeout_id got %0d want 0", timeout_id); end
    rst = 1'b0;
    step(1);
    $display("reset released: grant=%b bus_util=%b cycle %0d", grant, bus_util, cyc);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL first_grant got %b want 0001", grant); end
    checks++; if (bus_util !== 1'b1) begin errors++; $display("FAIL first_bus_util got %b want 1", bus_util); end
    step(2);
    rst = 1'b1;
    step(1);
    $display("reset mid-hold: grant=%b timeout_err=%b", grant, timeout_err);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL midhold_reset_grant got %b want 0000", grant); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL midhold_reset_err got %b want 0", timeout_err); end
    checks++; if (bus_util !== 1'b0) begin errors++; $display("FAIL midhold_reset_util got %b want 0", bus_util); end
    rst = 1'b0; m_req = '0;
    step(1);
  endtask

  task automatic test_round_robin;
    int n;
    logic [NM-1:0] exp_g;
    int exp_id [5] = '{0, 1, 2, 3, 0};
    m_req = 4'b1111;
    step(1);
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << exp_id[k];
      $display("rr tenure %0d: grant=%b id=%0d cycle %0d", k, grant, grant_id, cyc);
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", k, grant, exp_g); end
      checks++; if (bus_util !== (|grant)) begin errors++; $display("FAIL rr_util[%0d] got %b want %b", k, bus_util, |grant); end
      step(4);
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_hold[%0d] got %b want %b", k, grant, exp_g); end
      m_req[exp_id[k]] = 1'b0;
      step(1);
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rr_release[%0d] got %b want 0000", k, grant); end
      if (k < 4) begin
        m_req[exp_id[k]] = 1'b1;
        wait_grant(n);
        checks++; if (n !== 3) begin errors++; $display("FAIL rr_gap_latency[%0d] got %0d want 3", k, n); end
      end
    end
    m_req = '0;
    step(3);
  endtask

  task automatic test_single;
    int n;
    m_req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant[%0d] got %b want 0100", i, grant); end
    end
    m_req = '0;
    step(1);
    $display("single requester released: grant=%b bus_util=%b cycle %0d", grant, bus_util, cyc);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_release got %b want 0000", grant); end
    checks++; if (bus_util !== 1'b0) begin errors++; $display("FAIL single_util got %b want 0", bus_util); end
    m_req = 4'b0101;
    wait_grant(n);
    $display("wrap-around request 0101: grant=%b id=%0d", grant, grant_id);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL wrap_grant got %b want 0001", grant); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL wrap_grant_id got %0d want 0", grant_id); end
    m_req = '0;
    step(4);
  endtask

  task automatic test_timeout;
    int n;
    m_req = 4'b0110;
    step(1);
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL to_grant got %b want 0010", grant); end
    n = 0;
    while (grant != '0 && n < 20) begin
      step(1);
      n++;
    end
    $display("timeout revoke after %0d cycles: err=%b id=%0d", n, timeout_err, timeout_id);
    checks++; if (n !== 8) begin errors++; $display("FAIL to_hold_cycles got %0d want 8", n); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_pulse got %b want 1", timeout_err); end
    checks++; if (timeout_id !== 2'd1) begin errors++; $display("FAIL to_id got %0d want 1", timeout_id); end
    step(1);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_one_cycle got %b want 0", timeout_err); end
    checks++; if (timeout_id !== 2'd1) begin errors++; $display("FAIL to_id_held got %0d want 1", timeout_id); end
    wait_grant(n);
    $display("after gap: grant=%b after %0d more cycles", grant, n);
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL to_next_grant got %b want 0100", grant); end
    checks++; if (n !== 2) begin errors++; $display("FAIL to_next_latency got %0d want 2", n); end
  endtask

  // Master 2 already owns the bus from the previous task (grant just arrived).
  task automatic test_freeze;
    int n;
    m_req = 4'b0100;
    n = 0;
    while (grant != '0 && n < 60) begin
      if (n == 3)  slave_busy = 1'b1;
      if (n == 23) slave_busy = 1'b0;
      step(1);
      n++;
    end
    $display("frozen timeout revoke after %0d cycles: err=%b id=%0d", n, timeout_err, timeout_id);
    checks++; if (n !== 28) begin errors++; $display("FAIL freeze_hold_cycles got %0d want 28", n); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL freeze_err got %b want 1", timeout_err); end
    checks++; if (timeout_id !== 2'd2) begin errors++; $display("FAIL freeze_id got %0d want 2", timeout_id); end
    m_req = '0;
    step(4);
  endtask

  task automatic test_simultaneous;
    int n;
    m_req = 4'b1000;
    step(1);
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL sim_grant got %b want 1000", grant); end
    step(3);
    m_req = 4'b1001;
    step(4);
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL sim_no_preempt got %b want 1000", grant); end
    m_req = 4'b0001;
    step(1);
    $display("release at limit: grant=%b err=%b timeout_id=%0d", grant, timeout_err, timeout_id);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL sim_release got %b want 0000", grant); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL sim_no_err got %b want 0", timeout_err); end
    checks++; if (timeout_id !== 2'd2) begin errors++; $display("FAIL sim_id_kept got %0d want 2", timeout_id); end
    wait_grant(n);
    $display("next owner: grant=%b after %0d cycles", grant, n);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL sim_next_grant got %b want 0001", grant); end
    checks++; if (n !== 3) begin errors++; $display("FAIL sim_next_latency got %0d want 3", n); end
    m_req = '0;
    step(4);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_timeout();
    test_freeze();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
